// File: rtl/mem_port_arbiter.sv
// Shared single-port SRAM arbiter between instruction fetch and data load/store.
// Data has priority; a bounded starvation counter guarantees fetch progress.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_rvalid,
  output logic        inst_stall,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_rvalid,
  output logic        data_stall,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  // state  | meaning
  // R_NONE | no read response due this cycle
  // R_INST | sram_rdata carries the fetch issued last cycle
  // R_DATA | sram_rdata carries the load issued last cycle
  typedef enum logic [1:0] {R_NONE, R_INST, R_DATA} resp_e;

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  resp_e          r_state;
  logic [CW-1:0]  starve_cnt;
  logic           inst_wins;
  logic           inst_grant;
  logic           data_grant;

  always_comb begin
    inst_wins  = inst_req && (starve_cnt == CW'(STARVE_MAX));
    data_grant = !rst && data_req && !inst_wins;
    inst_grant = !rst && inst_req && !data_grant;
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = 4'b0;
    sram_addr  = 32'b0;
    sram_wdata = 32'b0;
    if (data_grant) begin
      sram_en    = 1'b1;
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (inst_grant) begin
      sram_en    = 1'b1;
      sram_addr  = inst_addr;
    end
  end

  assign inst_stall  = !rst && inst_req && !inst_grant;
  assign data_stall  = !rst && data_req && !data_grant;

  // Gating with rst keeps a response in flight at reset from leaking out.
  assign inst_rvalid = !rst && (r_state == R_INST);
  assign data_rvalid = !rst && (r_state == R_DATA);
  assign inst_rdata  = inst_rvalid ? sram_rdata : 32'b0;
  assign data_rdata  = data_rvalid ? sram_rdata : 32'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= R_NONE;
      starve_cnt <= '0;
    end else begin
      if (inst_grant)
        r_state <= R_INST;
      else if (data_grant && (data_wen == 4'b0))
        r_state <= R_DATA;
      else
        r_state <= R_NONE;

      if (inst_grant || !inst_req)
        starve_cnt <= '0;
      else if (data_grant && (starve_cnt != CW'(STARVE_MAX)))
        starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a rule-level reference model predicts
// grants and read responses; a negedge monitor checks responses as they appear.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_wen;
  logic [31:0] inst_rdata, data_rdata, sram_addr, sram_wdata, sram_rdata;
  logic        inst_rvalid, inst_stall, data_rvalid, data_stall, sram_en;
  logic [3:0]  sram_wen;

  mem_port_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_rvalid(inst_rvalid), .inst_stall(inst_stall),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_rvalid(data_rvalid),
    .data_stall(data_stall), .sram_en(sram_en), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_inst;
    logic [31:0] data;
    int          cyc;
  } resp_t;

  resp_t       q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          m_starve = 0;
  logic [31:0] sram_mem [256];
  logic [31:0] ref_mem  [256];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Behavioural SRAM: one-cycle read latency, byte-lane writes, garbage otherwise.
  always @(posedge clk) begin
    if (sram_en && sram_wen == 4'b0)
      sram_rdata <= sram_mem[sram_addr[9:2]];
    else
      sram_rdata <= $urandom;
    if (sram_en)
      for (int b = 0; b < 4; b++)
        if (sram_wen[b]) sram_mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
  end

  // Response monitor
  always @(negedge clk) begin
    resp_t e;
    chk("both_rvalid", {63'b0, inst_rvalid & data_rvalid}, 64'd0);
    chk("inst_rdata_idle", inst_rvalid ? 64'd0 : {32'b0, inst_rdata}, 64'd0);
    chk("data_rdata_idle", data_rvalid ? 64'd0 : {32'b0, data_rdata}, 64'd0);
    if (inst_rvalid || data_rvalid) begin
      if (q.size() == 0) begin
        chk("unexpected_rvalid", {62'b0, inst_rvalid, data_rvalid}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("resp_cycle", cyc, e.cyc);
        chk("resp_port", {63'b0, inst_rvalid}, {63'b0, e.is_inst});
        chk("resp_data", inst_rvalid ? inst_rdata : data_rdata, e.data);
      end
    end
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing_rvalid: got none expected response due cycle %0d", q[0].cyc);
      void'(q.pop_front());
    end
  end

  // One clock of stimulus; returns the model's grant and the DUT's observed data grant.
  task automatic step(input bit r, input bit ir, input logic [31:0] ia,
                      input bit dr, input logic [3:0] dw, input logic [31:0] da,
                      input logic [31:0] dwd, output bit eig, output bit edg, output bit dg_obs);
    resp_t e;
    rst = r; inst_req = ir; inst_addr = ia;
    data_req = dr; data_wen = dw; data_addr = da; data_wdata = dwd;
    if (r) q.delete();
    edg = !r && dr && !(ir && m_starve == SMAX);
    eig = !r && ir && !edg;
    @(negedge clk);
    if (r) begin
      chk("rst_outputs_zero",
          {63'b0, |{inst_rdata, inst_rvalid, inst_stall, data_rdata, data_rvalid,
                    data_stall, sram_en, sram_wen, sram_addr, sram_wdata}}, 64'd0);
    end else begin
      chk("grant_ctrl", {57'b0, sram_en, sram_wen, inst_stall, data_stall},
          {57'b0, eig | edg, edg ? dw : 4'b0, ir & ~eig, dr & ~edg});
      chk("sram_addr", {32'b0, sram_addr}, edg ? {32'b0, da} : eig ? {32'b0, ia} : 64'd0);
      chk("sram_wdata", {32'b0, sram_wdata}, edg ? {32'b0, dwd} : 64'd0);
    end
    dg_obs = data_req & ~data_stall;
    if (eig) begin
      e.is_inst = 1'b1; e.data = ref_mem[ia[9:2]]; e.cyc = cyc + 1;
      q.push_back(e);
    end else if (edg && dw == 4'b0) begin
      e.is_inst = 1'b0; e.data = ref_mem[da[9:2]]; e.cyc = cyc + 1;
      q.push_back(e);
    end else if (edg) begin
      for (int b = 0; b < 4; b++)
        if (dw[b]) ref_mem[da[9:2]][8*b +: 8] = dwd[8*b +: 8];
    end
    if (r || eig || !ir) m_starve = 0;
    else if (edg && m_starve < SMAX) m_starve++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a, b, c;
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, a, b, c);
  endtask

  initial begin
    bit          eig, edg, dgo;
    logic [5:0]  dg_seq;
    bit          pi, pd;
    logic [31:0] pia, pda, pdwd;
    logic [3:0]  pdw;

    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = $urandom;
      ref_mem[i]  = sram_mem[i];
    end
    rst = 1'b1; inst_req = 0; data_req = 0; inst_addr = 0; data_addr = 0;
    data_wen = 0; data_wdata = 0;
    @(posedge clk); #1;

    // Reset with requests asserted: grant forced off, everything zero
    for (int i = 0; i < 3; i++)
      step(1, 1, $urandom, 1, 4'h0, $urandom, $urandom, eig, edg, dgo);
    idle(1);
    chk("starve_after_reset", {61'b0, dut.starve_cnt}, 64'd0);

    // Single fetch from the boot vector
    step(0, 1, 32'hBFC0_0000, 0, 4'h0, 32'h0, 32'h0, eig, edg, dgo);
    idle(1);

    // Simultaneous fetch and load: data first, then fetch while load returns
    step(0, 1, 32'h0000_0040, 1, 4'h0, 32'h0000_0100, 32'h0, eig, edg, dgo);
    chk("both_req_data_first", {63'b0, dgo}, 64'd1);
    step(0, 1, 32'h0000_0040, 0, 4'h0, 32'h0, 32'h0, eig, edg, dgo);
    idle(1);

    // Starvation bound: 4 data grants, fetch on the 5th, then data again
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 32'h0000_0200, 1, 4'h0, 32'h0000_0300 + 32'(4 * i), 32'h0, eig, edg, dgo);
      dg_seq[i] = dgo;
    end
    chk("starve_sequence", {58'b0, dg_seq}, 64'b101111);
    idle(1);

    // Partial store, no response, then read back the merged word
    step(0, 0, 32'h0, 1, 4'b0011, 32'h0000_0080, 32'hDEAD_BEEF, eig, edg, dgo);
    idle(1);
    step(0, 0, 32'h0, 1, 4'b0000, 32'h0000_0080, 32'h0, eig, edg, dgo);
    idle(1);

    // Back-to-back fetches
    for (int i = 0; i < 4; i++)
      step(0, 1, 32'h0000_1000 + 32'(4 * i), 0, 4'h0, 32'h0, 32'h0, eig, edg, dgo);
    idle(2);

    // Reset right after a load grant, with the starvation counter nonzero
    for (int i = 0; i < 3; i++)
      step(0, 1, 32'h0000_0020, 1, 4'h0, 32'h0000_0024, 32'h0, eig, edg, dgo);
    step(1, 1, 32'h0000_0020, 0, 4'h0, 32'h0, 32'h0, eig, edg, dgo);
    idle(1);
    chk("starve_cleared_by_reset", {61'b0, dut.starve_cnt}, 64'd0);
    idle(1);

    // Randomized traffic, requests held until granted
    pi = 0; pd = 0; pia = 0; pda = 0; pdwd = 0; pdw = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pi && ($urandom_range(0, 2) != 0)) begin
        pi = 1; pia = $urandom & 32'hFFFF_FFFC;
      end
      if (!pd && ($urandom_range(0, 2) != 0)) begin
        pd = 1; pda = $urandom & 32'hFFFF_FFFC; pdwd = $urandom;
        pdw = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      step(($urandom_range(0, 63) == 0), pi, pia, pd, pdw, pda, pdwd, eig, edg, dgo);
      if (eig) pi = 0;
      if (edg) pd = 0;
    end
    idle(3);
    chk("queue_drained", q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: max consecutive data grants while inst_req is waiting.
REQ-002 SHALL have port clk, input, 1: the single clock; every flop is clocked on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port inst_req, input, 1: fetch request; held with inst_addr until granted.
REQ-005 SHALL have port inst_addr, input, 32: fetch byte address.
REQ-006 SHALL have port inst_rdata, output, 32: fetch read data.
REQ-007 SHALL have port inst_rvalid, output, 1: inst_rdata valid this cycle.
REQ-008 SHALL have port inst_stall, output, 1: inst_req pending and not granted.
REQ-009 SHALL have port data_req, input, 1: load/store request; held with its fields until granted.
REQ-010 SHALL have port data_wen, input, 4: byte write enables; 0 means read.
REQ-011 SHALL have port data_addr, input, 32: data byte address.
REQ-012 SHALL have port data_wdata, input, 32: store data.
REQ-013 SHALL have port data_rdata, output, 32: load read data.
REQ-014 SHALL have port data_rvalid, output, 1: data_rdata valid this cycle (loads only).
REQ-015 SHALL have port data_stall, output, 1: data_req pending and not granted.
REQ-016 SHALL have port sram_en, output, 1: shared SRAM access strobe.
REQ-017 SHALL have port sram_wen, output, 4: shared SRAM byte write enables.
REQ-018 SHALL have port sram_addr, output, 32: shared SRAM address.
REQ-019 SHALL have port sram_wdata, output, 32: shared SRAM write data.
REQ-020 SHALL have port sram_rdata, input, 32: shared SRAM read data; valid one cycle after the access.

Function
REQ-021 SHALL grant at most one requester per cycle; the grant is combinational from the requests and the registered state.
REQ-022 SHALL grant data over inst when both request, except that inst wins when starve_cnt == STARVE_MAX.
REQ-023 starve_cnt SHALL increment (saturating at STARVE_MAX) on a cycle with a data grant while inst_req=1; it SHALL clear on an inst grant or when inst_req=0.
REQ-024 SHALL drive on a grant: sram_en=1, sram_addr = granted address, sram_wen = data_wen (data grant) or 4'b0 (inst grant), sram_wdata = data_wdata (data grant) or 32'b0 (inst grant).
REQ-025 SHALL drive when there is no grant: sram_en=0, sram_wen=0, sram_addr=0, sram_wdata=0.
REQ-026 SHALL compute inst_stall = inst_req & ~inst_grant and data_stall = data_req & ~data_grant, both combinational.
REQ-027 SHALL keep a response FSM with states R_NONE, R_INST and R_DATA.
REQ-028 The FSM next state SHALL be R_INST after an inst grant, R_DATA after a data read grant, and R_NONE otherwise (includes a write grant).
REQ-029 SHALL assert inst_rvalid=1 only in R_INST, and data_rvalid=1 only in R_DATA; read latency is exactly 1 cycle after the grant.
REQ-030 SHALL drive inst_rdata and data_rdata from sram_rdata when the matching rvalid is 1, and 0 otherwise.
REQ-031 SHALL allow back-to-back grants every cycle; a new grant SHALL be issued in the same cycle a previous response returns.
REQ-032 SHALL complete a store in its grant cycle and SHALL produce no rvalid for it.
REQ-033 SHALL NOT assert both rvalids in the same cycle.

Reset
REQ-034 When rst=1 at a clock edge, SHALL set FSM=R_NONE and starve_cnt=0.
REQ-035 SHALL drive all outputs to 0 while rst=1, with the grant forced off.
REQ-036 A response outstanding at reset SHALL be discarded: no rvalid in the cycle after reset deasserts.

Verification
REQ-037 Bench SHALL cover: inst_req=1 alone, addr 0xBFC00000 -> sram_en=1, sram_addr=0xBFC00000; next cycle inst_rvalid=1, inst_rdata = sram_rdata.
REQ-038 Bench SHALL cover: inst_req and data read both asserted, data_addr 0x100 -> data granted, inst_stall=1; next cycle data_rvalid=1 and inst granted.
REQ-039 Bench SHALL cover: data_req held with inst_req for 6 cycles, STARVE_MAX=4 -> 4 data grants, then an inst grant in cycle 5, then data again.
REQ-040 Bench SHALL cover: store with data_wen=4'b0011, wdata 0xDEADBEEF -> sram_wen=0011 in the grant cycle, no data_rvalid in the next cycle.
REQ-041 Bench SHALL cover: inst fetches every cycle for 4 cycles -> sram_en=1 every cycle, inst_rvalid=1 in cycles 2-5.
REQ-042 Bench SHALL cover: rst=1 in the cycle after a data read grant -> data_rvalid=0, all outputs 0, starve_cnt=0.
